// File: rtl/img_sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// img_sram_pkg
//   Shared types and default widths for the image SRAM arbiter slice.
//   - ROW_W_DEF / COL_W_DEF / DATA_W_DEF : default SRAM address/data widths
//   - LAT_W                              : width of the read latency counter
//                                          (READ_LAT is limited to 1..4)
//   - arb_state_t                        : sequencer states
//   - req_t                              : one request beat at default widths
//   - id_width()                         : width of a requester index
// ---------------------------------------------------------------------------
package img_sram_pkg;

   localparam int ROW_W_DEF  = 8;
   localparam int COL_W_DEF  = 8;
   localparam int DATA_W_DEF = 8;
   localparam int LAT_W      = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD      = 2'd2,
      RD_WAIT = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic [ROW_W_DEF-1:0]  row;
      logic [COL_W_DEF-1:0]  col;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

   // A single requester still needs a 1-bit index.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_sram_arb_if.sv
// ---------------------------------------------------------------------------
// img_sram_arb_if
//   Requester-side bus of the image SRAM arbiter.
//
//   Handshake: requester r holds req_valid[r] and its we/row/col/wdata fields
//   stable until it observes req_ready[r]; the beat transfers on the rising
//   clock edge where req_valid[r] && req_ready[r]. req_ready is at most
//   one-hot. rsp_valid[r] is a one-cycle pulse qualifying the shared
//   rsp_rdata bus for requester r.
//
//   modport master : requesters (drive req_*, observe ready and responses)
//   modport slave  : arbiter
// ---------------------------------------------------------------------------
interface img_sram_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int ROW_W   = img_sram_pkg::ROW_W_DEF,
   parameter int COL_W   = img_sram_pkg::COL_W_DEF,
   parameter int DATA_W  = img_sram_pkg::DATA_W_DEF
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ-1:0][ROW_W-1:0]  req_row;
   logic [NUM_REQ-1:0][COL_W-1:0]  req_col;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [DATA_W-1:0]              rsp_rdata;

   modport master (
      output req_valid, req_we, req_row, req_col, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_row, req_col, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/img_sram_rr_arb.sv
// ---------------------------------------------------------------------------
// img_sram_rr_arb
//   Combinational winner select over a request vector.
//   Default: round-robin. The search starts one past the last winner
//   (ptr_q) and the pointer moves to the winner whenever grant_en is high
//   and someone is requesting. ptr_q resets to NUM_REQ-1 so requester 0
//   is first after reset.
//   With IMG_SRAM_ARB_FIXED_PRIO_EN defined: lowest index wins, no pointer.
//
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     valid      : request vector
//     grant_en   : the grant is being taken this cycle (update pointer)
//     any_valid  : at least one request present
//     grant      : one-hot winner (zero when nothing is valid)
//     grant_id   : index of the winner
// ---------------------------------------------------------------------------
module img_sram_rr_arb
   import img_sram_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               grant_en,
   output logic               any_valid,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   assign any_valid = |valid;

`ifdef IMG_SRAM_ARB_FIXED_PRIO_EN

   // Scan from the top so the lowest valid index is the last one written.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            grant_id = ID_W'(i);
         end
      end
   end

   logic unused_fixed;
   assign unused_fixed = ^{clk, rst, grant_en};

`else

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;

   // Walk NUM_REQ slots clockwise starting one past the last winner; the
   // first valid slot wins.
   always_comb begin
      int   idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      grant    = '0;
      grant_id = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && valid[idx[ID_W-1:0]]) begin
            found                  = 1'b1;
            grant[idx[ID_W-1:0]]   = 1'b1;
            grant_id               = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en && any_valid) begin
         ptr_d = grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

endmodule

// File: rtl/img_sram_arb.sv
// ---------------------------------------------------------------------------
// img_sram_arb
//   Shares one image SRAM macro between NUM_REQ single-beat requesters.
//   One request is accepted per IDLE visit; the sequencer then produces a
//   one-cycle write strobe (WR) or a one-cycle sense strobe (RD) followed by
//   READ_LAT cycles in RD_WAIT, after which the read data is returned to the
//   owning requester with a one-cycle rsp_valid pulse.
//
//   Timing from the grant cycle (cycle 0):
//     write : write_en in cycle 1, back in IDLE in cycle 2
//     read  : sense_en in cycle 1, rsp_valid in cycle 2+READ_LAT
//
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     bus (slave)     : requester handshake and response bus
//     busy            : sequencer not in IDLE
//     sram_row/col/din: registered SRAM address/data, held between strobes
//     sram_write_en   : SRAM write strobe
//     sram_sense_en   : SRAM read strobe
//     sram_dout       : SRAM read data
//     state_dbg       : current sequencer state
//
//   Build option: define IMG_SRAM_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins) instead of round-robin.
// ---------------------------------------------------------------------------
module img_sram_arb
   import img_sram_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int ROW_W    = ROW_W_DEF,
   parameter int COL_W    = COL_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   img_sram_arb_if.slave     bus,
   output logic              busy,
   output logic [ROW_W-1:0]  sram_row,
   output logic [COL_W-1:0]  sram_col,
   output logic [DATA_W-1:0] sram_din,
   output logic              sram_write_en,
   output logic              sram_sense_en,
   input  logic [DATA_W-1:0] sram_dout,
   output arb_state_t        state_dbg
);

   localparam int ID_W = id_width(NUM_REQ);

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [DATA_W-1:0]  din_q, din_d;
   logic               write_en_q, write_en_d;
   logic               sense_en_q, sense_en_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic               busy_q, busy_d;

   logic               any_valid;
   logic               grant_en;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;

   // Grants are only offered in IDLE; rst is folded in so req_ready is low
   // for the whole reset window, not just once the state is cleared.
   assign grant_en = (state_q == IDLE) && !rst;

   img_sram_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (bus.req_valid),
      .grant_en  (grant_en),
      .any_valid (any_valid),
      .grant     (grant),
      .grant_id  (grant_id)
   );

   assign bus.req_ready = grant_en ? grant : '0;

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      row_d       = row_q;
      col_d       = col_q;
      din_d       = din_q;
      write_en_d  = 1'b0;
      sense_en_d  = 1'b0;
      lat_d       = lat_q;
      rdata_d     = rdata_q;
      rsp_valid_d = '0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               id_d  = grant_id;
               row_d = bus.req_row[grant_id];
               col_d = bus.req_col[grant_id];
               din_d = bus.req_wdata[grant_id];
               if (bus.req_we[grant_id]) begin
                  state_d    = WR;
                  write_en_d = 1'b1;
               end else begin
                  state_d    = RD;
                  sense_en_d = 1'b1;
               end
            end
         end
         WR: begin
            state_d = IDLE;
         end
         RD: begin
            state_d = RD_WAIT;
            lat_d   = LAT_W'(READ_LAT - 1);
         end
         RD_WAIT: begin
            if (lat_q == '0) begin
               rdata_d           = sram_dout;
               rsp_valid_d[id_q] = 1'b1;
               state_d           = IDLE;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         id_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         din_q       <= '0;
         write_en_q  <= 1'b0;
         sense_en_q  <= 1'b0;
         lat_q       <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         row_q       <= row_d;
         col_q       <= col_d;
         din_q       <= din_d;
         write_en_q  <= write_en_d;
         sense_en_q  <= sense_en_d;
         lat_q       <= lat_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign busy          = busy_q;
   assign sram_row      = row_q;
   assign sram_col      = col_q;
   assign sram_din      = din_q;
   assign sram_write_en = write_en_q;
   assign sram_sense_en = sense_en_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign state_dbg     = state_q;

   // A requester must not withdraw a request before it is granted.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
      a_valid_hold: assert property (@(posedge clk) disable iff (rst)
         (bus.req_valid[g] && !bus.req_ready[g]) |=> bus.req_valid[g]);
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(bus.req_ready));

   a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
      !(sram_write_en && sram_sense_en));

endmodule

// File: tb/tb_img_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_img_sram_arb
//   Bench for img_sram_arb with NUM_REQ=4, READ_LAT=2. A behavioural SRAM
//   sits on the memory side. Requester drivers issue beats; a monitor keeps
//   a reference memory updated in grant order, predicts the winner from the
//   arbitration rule, and queues the expected strobes and responses with
//   the cycle they are due.
// ---------------------------------------------------------------------------
module tb_img_sram_arb;
   import img_sram_pkg::*;

   localparam int N      = 4;
   localparam int RL     = 2;
   localparam int ROW_W  = 8;
   localparam int COL_W  = 8;
   localparam int DATA_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   img_sram_arb_if #(.NUM_REQ(N), .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) bus ();

   logic              busy;
   logic [ROW_W-1:0]  sram_row;
   logic [COL_W-1:0]  sram_col;
   logic [DATA_W-1:0] sram_din;
   logic              sram_write_en;
   logic              sram_sense_en;
   logic [DATA_W-1:0] sram_dout;
   arb_state_t        state_dbg;

   img_sram_arb #(
      .NUM_REQ(N), .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W), .READ_LAT(RL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .busy          (busy),
      .sram_row      (sram_row),
      .sram_col      (sram_col),
      .sram_din      (sram_din),
      .sram_write_en (sram_write_en),
      .sram_sense_en (sram_sense_en),
      .sram_dout     (sram_dout),
      .state_dbg     (state_dbg)
   );

   // ---------------- behavioural SRAM ----------------
   // Data read in the sense cycle appears on dout RL cycles later; other
   // cycles carry noise so a mistimed capture shows up.
   logic [DATA_W-1:0] sram_mem [0:65535];
   logic [DATA_W-1:0] rd_pipe  [0:RL-1];
   always @(posedge clk) begin
      if (sram_write_en) sram_mem[{sram_row, sram_col}] <= sram_din;
      rd_pipe[0] <= sram_sense_en ? sram_mem[{sram_row, sram_col}] : DATA_W'($urandom);
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign sram_dout = rd_pipe[RL-1];

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;

   typedef struct {
      int                cyc;
      bit                we;
      logic [ROW_W-1:0]  row;
      logic [COL_W-1:0]  col;
      logic [DATA_W-1:0] din;
   } strobe_t;

   typedef struct {
      int                cyc;
      int                id;
      logic [DATA_W-1:0] data;
   } rsp_t;

   strobe_t           exp_strobe_q[$];
   rsp_t              exp_rsp_q[$];
   logic [DATA_W-1:0] ref_mem [0:65535];
   int                grant_log[$];
   int                last_grant = N - 1;
   int                busy_last  = -1;
   int                max_wait   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arbitration rule: round-robin picks the valid requester at the
   // shortest clockwise distance past the previous winner; fixed priority
   // picks the lowest valid index.
   function automatic int model_winner(input logic [N-1:0] v, input int last);
      int best;
      int best_d;
      int d;
      best   = -1;
      best_d = N + 1;
      for (int k = 0; k < N; k++) begin
         if (v[k]) begin
`ifdef IMG_SRAM_ARB_FIXED_PRIO_EN
            d = k;
`else
            d = (k - last - 1 + 2 * N) % N;
`endif
            if (d < best_d) begin
               best_d = d;
               best   = k;
            end
         end
      end
      return best;
   endfunction

   // ---------------- monitor ----------------
   logic [N-1:0]     m_exp_ready;
   logic [N-1:0]     m_exp_rv;
   logic             m_exp_busy;
   logic             m_exp_we;
   logic             m_exp_se;
   int               m_w;
   strobe_t          m_s;
   rsp_t             m_r;
   logic [15:0]      m_addr;

   always @(negedge clk) begin
      if (rst) begin
         exp_strobe_q.delete();
         exp_rsp_q.delete();
         last_grant = N - 1;
         busy_last  = -1;
      end else begin
         m_exp_busy = (cyc <= busy_last);
         check("busy", busy, m_exp_busy);

         // strobes due this cycle
         m_exp_we = 1'b0;
         m_exp_se = 1'b0;
         if (exp_strobe_q.size() > 0 && exp_strobe_q[0].cyc == cyc) begin
            m_exp_we = exp_strobe_q[0].we;
            m_exp_se = !exp_strobe_q[0].we;
         end
         if (sram_write_en || sram_sense_en || m_exp_we || m_exp_se) begin
            check("write_en", sram_write_en, m_exp_we);
            check("sense_en", sram_sense_en, m_exp_se);
            if (m_exp_we || m_exp_se) begin
               m_s = exp_strobe_q.pop_front();
               check("sram_row", sram_row, m_s.row);
               check("sram_col", sram_col, m_s.col);
               if (m_s.we) check("sram_din", sram_din, m_s.din);
            end
         end

         // responses due this cycle
         m_exp_rv = '0;
         if (exp_rsp_q.size() > 0 && exp_rsp_q[0].cyc == cyc) m_exp_rv[exp_rsp_q[0].id] = 1'b1;
         if (bus.rsp_valid != 0 || m_exp_rv != 0) begin
            check("rsp_valid", bus.rsp_valid, m_exp_rv);
            if (m_exp_rv != 0) begin
               m_r = exp_rsp_q.pop_front();
               check("rsp_rdata", bus.rsp_rdata, m_r.data);
            end
         end

         // grant prediction and bookkeeping
         m_exp_ready = '0;
         m_w = -1;
         if (!m_exp_busy && bus.req_valid != 0) begin
            m_w = model_winner(bus.req_valid, last_grant);
            m_exp_ready[m_w] = 1'b1;
         end
         if (m_exp_ready != 0 || bus.req_ready != 0) check("req_ready", bus.req_ready, m_exp_ready);
         if (m_w >= 0) begin
            grant_log.push_back(m_w);
            last_grant = m_w;
            m_addr     = {bus.req_row[m_w], bus.req_col[m_w]};
            m_s.cyc = cyc + 1;
            m_s.we  = bus.req_we[m_w];
            m_s.row = bus.req_row[m_w];
            m_s.col = bus.req_col[m_w];
            m_s.din = bus.req_wdata[m_w];
            exp_strobe_q.push_back(m_s);
            if (bus.req_we[m_w]) begin
               ref_mem[m_addr] = bus.req_wdata[m_w];
               busy_last = cyc + 1;
            end else begin
               m_r.cyc  = cyc + 2 + RL;
               m_r.id   = m_w;
               m_r.data = ref_mem[m_addr];
               exp_rsp_q.push_back(m_r);
               busy_last = cyc + 1 + RL;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the edge on which
   // the beat transferred, with valid dropped.
   task automatic drive_req(input int r, input bit we, input logic [ROW_W-1:0] row,
                            input logic [COL_W-1:0] col, input logic [DATA_W-1:0] wdata);
      int waited;
      int start_grants;
      waited             = 0;
      bus.req_we[r]      = we;
      bus.req_row[r]     = row;
      bus.req_col[r]     = col;
      bus.req_wdata[r]   = wdata;
      bus.req_valid[r]   = 1'b1;
      start_grants       = grant_log.size();
      while (1) begin
         @(negedge clk);
         if (bus.req_ready[r]) break;
         waited++;
         if (waited > 200) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: requester %0d not granted within 200 cycles", r);
            return;
         end
      end
      @(posedge clk);
      #1;
      if (grant_log.size() - start_grants > max_wait) max_wait = grant_log.size() - start_grants;
      bus.req_valid[r] = 1'b0;
   endtask

   task automatic run_traffic(input int r, input int n, input int gap_max);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, gap_max)) @(posedge clk);
         #1;
         drive_req(r, 1'($urandom_range(0, 1)), ROW_W'($urandom_range(0, 7)),
                   COL_W'($urandom_range(0, 7)), DATA_W'($urandom));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, '0);
      check({tag, "_rsp_valid"}, bus.rsp_valid, '0);
      check({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_write_en"}, sram_write_en, 1'b0);
      check({tag, "_sense_en"}, sram_sense_en, 1'b0);
      check({tag, "_sram_row"}, sram_row, '0);
      check({tag, "_sram_din"}, sram_din, '0);
      check({tag, "_state"}, state_dbg, IDLE);
   endtask

   // ---------------- main sequence ----------------
   int alt_exp [8];
   int log_start;
   int cnt [N];
   logic [DATA_W-1:0] wd;

   initial begin
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_row   = '0;
      bus.req_col   = '0;
      bus.req_wdata = '0;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            wd = DATA_W'($urandom);
            sram_mem[{ROW_W'(a), COL_W'(b)}] <= wd;
            ref_mem[{ROW_W'(a), COL_W'(b)}] = wd;
         end
      end
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // directed write then directed read of the same word
      @(posedge clk);
      #1;
      drive_req(0, 1'b1, 8'd3, 8'd5, 8'hA5);
      repeat (2) @(posedge clk);
      #1;
      drive_req(1, 1'b0, 8'd3, 8'd5, 8'h00);
      repeat (RL + 3) @(posedge clk);
      @(negedge clk);
      check("directed_readback", bus.rsp_rdata, 8'hA5);
      @(posedge clk);
      #1;

      // two requesters held continuously
`ifdef IMG_SRAM_ARB_FIXED_PRIO_EN
      alt_exp = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
      alt_exp = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
      log_start = grant_log.size();
      fork
         run_traffic(0, 4, 0);
         run_traffic(1, 4, 0);
      join
      for (int k = 0; k < 8; k++) check("alternation", grant_log[log_start + k], alt_exp[k]);

      // back-to-back write then read of the same address
      wd = DATA_W'($urandom);
      drive_req(2, 1'b1, 8'd6, 8'd6, wd);
      drive_req(2, 1'b0, 8'd6, 8'd6, 8'h00);
      repeat (RL + 2) @(posedge clk);
      @(negedge clk);
      check("wr_rd_readback", bus.rsp_rdata, wd);
      @(posedge clk);
      #1;

      // reset while a read waits for data
      drive_req(3, 1'b0, 8'd3, 8'd5, 8'h00);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_outputs_zero("midread");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      log_start = grant_log.size();
      fork
         drive_req(1, 1'b1, 8'd1, 8'd1, 8'h11);
         drive_req(0, 1'b1, 8'd0, 8'd0, 8'h22);
      join
      check("post_reset_first_grant", grant_log[log_start], 0);

      // four requesters, all valid, 16 operations
      max_wait  = 0;
      log_start = grant_log.size();
      fork
         run_traffic(0, 4, 0);
         run_traffic(1, 4, 0);
         run_traffic(2, 4, 0);
         run_traffic(3, 4, 0);
      join
      for (int r = 0; r < N; r++) cnt[r] = 0;
      for (int k = log_start; k < grant_log.size(); k++) cnt[grant_log[k]]++;
      for (int r = 0; r < N; r++) check("fair_count", cnt[r], 4);
`ifndef IMG_SRAM_ARB_FIXED_PRIO_EN
      check("max_wait_ok", max_wait <= N, 1'b1);
`endif

      // random traffic with gaps
      fork
         run_traffic(0, 12, 3);
         run_traffic(1, 12, 3);
         run_traffic(2, 12, 3);
         run_traffic(3, 12, 3);
      join

      repeat (RL + 6) @(posedge clk);
      @(negedge clk);
      check("pending_expectations", exp_strobe_q.size() + exp_rsp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
